mul_iter_unit: RTL

//  Multi-cycle RV64M multiply functional unit in stage3. Accepts MUL/MULH/MULHSU/MULHU/MULW ops.

---
 rtl/fu_pkg.sv | 33 +++
 rtl/sub_mul.sv | 32 +++
 rtl/mul_iter_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fu_pkg.sv
// Shared types for the stage-3 functional units: multiply opcodes, FSM state
// encoding, and the per-opcode operand signedness lookup.
package fu_pkg;

   typedef enum logic [2:0] {
      MUL,
      MULH,
      MULHSU,
      MULHU,
      MULW
   } mul_op_t;

   typedef enum logic [1:0] {
      StIdle,
      StMult,
      StFix,
      StDone
   } mul_state_t;

   localparam int unsigned WORD_W = 32;

   // Returns {a_signed, b_signed}; MULW operands are sign-extended words.
   function automatic logic [1:0] mul_signs(mul_op_t op);
      logic [1:0] signs;
      case (op)
         MUL, MULH, MULW: signs = 2'b11;
         MULHSU:          signs = 2'b10;
         default:         signs = 2'b00;
      endcase
      return signs;
   endfunction

endpackage

// File: rtl/sub_mul.sv
// Unsigned SUB_W x SUB_W multiplier: a plain operator when a hard multiplier
// is wanted, otherwise a combinational shift-add array in fabric.
module sub_mul #(
   parameter int unsigned SUB_W   = 16,
   parameter int unsigned USE_DSP = 0
) (
   input  logic [SUB_W-1:0]   i_a,
   input  logic [SUB_W-1:0]   i_b,
   output logic [2*SUB_W-1:0] o_p
);

   if (USE_DSP != 0) begin : g_dsp
      assign o_p = {{SUB_W{1'b0}}, i_a} * {{SUB_W{1'b0}}, i_b};
   end else begin : g_fabric
      logic [2*SUB_W-1:0] w_a_ext;
      logic [2*SUB_W-1:0] w_sum;

      assign w_a_ext = {{SUB_W{1'b0}}, i_a};

      always_comb begin
         w_sum = '0;
         for (int k = 0; k < int'(SUB_W); k++) begin
            if (i_b[k]) begin
               w_sum = w_sum + (w_a_ext << k);
            end
         end
      end

      assign o_p = w_sum;
   end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative RV64M multiplier: one chunk pair per cycle through a single sub_mul,
// accumulated as an unsigned magnitude, then sign-fixed and selected.
module mul_iter_unit
   import fu_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned SUB_W   = 16,
   parameter int unsigned TAG_W   = 5,
   parameter int unsigned USE_DSP = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  mul_op_t          in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned CH    = XLEN / SUB_W;
   localparam int unsigned IDX_W = (CH > 1) ? $clog2(CH) : 1;
   localparam int unsigned ACC_W = 2 * XLEN;

   mul_state_t         r_state;
   mul_state_t         w_state_d;
   mul_op_t            r_op;
   logic [XLEN-1:0]    r_a_mag;
   logic [XLEN-1:0]    r_b_mag;
   logic               r_neg;
   logic [TAG_W-1:0]   r_tag;
   logic [IDX_W-1:0]   r_ia;
   logic [IDX_W-1:0]   r_jb;
   logic [ACC_W-1:0]   r_acc;
   logic [XLEN-1:0]    r_result;

   logic               w_accept;
   logic               w_last_pair;
   logic [1:0]         w_signs;
   logic [XLEN-1:0]    w_a_ext;
   logic [XLEN-1:0]    w_b_ext;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [XLEN-1:0]    w_a_mag;
   logic [XLEN-1:0]    w_b_mag;
   logic [SUB_W-1:0]   w_a_chunk;
   logic [SUB_W-1:0]   w_b_chunk;
   logic [2*SUB_W-1:0] w_prod;
   logic [ACC_W-1:0]   w_pp;
   logic [ACC_W-1:0]   w_acc_fix;
   logic [XLEN-1:0]    w_result;

   // Operand preparation: MULW works on sign-extended low words.
   always_comb begin
      w_signs = mul_signs(in_op);
      if (in_op == MULW) begin
         w_a_ext = {{(XLEN-WORD_W){in_a[WORD_W-1]}}, in_a[WORD_W-1:0]};
         w_b_ext = {{(XLEN-WORD_W){in_b[WORD_W-1]}}, in_b[WORD_W-1:0]};
      end else begin
         w_a_ext = in_a;
         w_b_ext = in_b;
      end
      w_a_neg = w_signs[1] & w_a_ext[XLEN-1];
      w_b_neg = w_signs[0] & w_b_ext[XLEN-1];
      w_a_mag = w_a_neg ? (~w_a_ext + 1'b1) : w_a_ext;
      w_b_mag = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;
   end

   assign w_accept    = (r_state == StIdle) && in_valid && !flush;
   assign w_last_pair = (r_ia == IDX_W'(CH - 1)) && (r_jb == IDX_W'(CH - 1));

   assign w_a_chunk = r_a_mag[r_ia*SUB_W +: SUB_W];
   assign w_b_chunk = r_b_mag[r_jb*SUB_W +: SUB_W];

   sub_mul #(
      .SUB_W   (SUB_W),
      .USE_DSP (USE_DSP)
   ) u_sub_mul (
      .i_a (w_a_chunk),
      .i_b (w_b_chunk),
      .o_p (w_prod)
   );

   assign w_pp      = ACC_W'(w_prod) << (SUB_W * (32'(r_ia) + 32'(r_jb)));
   assign w_acc_fix = r_neg ? (~r_acc + 1'b1) : r_acc;

   always_comb begin
      case (r_op)
         MUL:     w_result = w_acc_fix[XLEN-1:0];
         MULW:    w_result = {{(XLEN-WORD_W){w_acc_fix[WORD_W-1]}}, w_acc_fix[WORD_W-1:0]};
         default: w_result = w_acc_fix[ACC_W-1:XLEN];
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (r_state)
         StIdle: begin
            in_ready = 1'b1;
            if (w_accept) begin
               w_state_d = StMult;
            end
         end
         StMult: begin
            if (w_last_pair) begin
               w_state_d = StFix;
            end
         end
         StFix: begin
            w_state_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
      if (flush) begin
         w_state_d = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= MUL;
         r_a_mag  <= '0;
         r_b_mag  <= '0;
         r_neg    <= 1'b0;
         r_tag    <= '0;
         r_ia     <= '0;
         r_jb     <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_op    <= in_op;
         r_a_mag <= w_a_mag;
         r_b_mag <= w_b_mag;
         r_neg   <= w_a_neg ^ w_b_neg;
         r_tag   <= in_tag;
         r_ia    <= '0;
         r_jb    <= '0;
         r_acc   <= '0;
      end else if ((r_state == StMult) && !flush) begin
         r_acc <= r_acc + w_pp;
         // b index runs fastest; a index steps when b wraps.
         if (r_jb == IDX_W'(CH - 1)) begin
            r_jb <= '0;
            r_ia <= r_ia + 1'b1;
         end else begin
            r_jb <= r_jb + 1'b1;
         end
      end else if ((r_state == StFix) && !flush) begin
         r_result <= w_result;
      end
   end

   assign out_result = r_result;
   assign out_tag    = r_tag;

endmodule
